onehot_decoder_seq: RTL
=======================

ONEHOT_DECODER_SEQ -- requirements
Module: onehot_decoder_seq

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning code width; output width is 2**N.
REQ-002 The block SHALL have parameter DWELL, default 100, meaning clock cycles each scan step is held; legal range 1..65535.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, meaning synchronous active-low reset.
REQ-005 The block SHALL have port en, input, 1, meaning global enable; low forces outputs to zero.
REQ-006 The block SHALL have port code, input, N, meaning the binary code to decode.
REQ-007 The block SHALL have port code_valid, input, 1, meaning code is presented.
REQ-008 The block SHALL have port code_ready, output, 1, meaning the block accepts code this cycle.
REQ-009 The block SHALL have port scan_start, input, 1, meaning a request to begin an automatic sweep of all codes.
REQ-010 The block SHALL have port o, output, 2**N, meaning registered one-hot output; bit k set for code k.
REQ-011 The block SHALL have port o_valid, output, 1, meaning o holds a decoded value.
REQ-012 The block SHALL have port idx, output, N, meaning the code currently driven on o.
REQ-013 The block SHALL have port scan_done, output, 1, meaning a one-cycle pulse when a sweep completes.

Function
REQ-014 The block SHALL implement states IDLE, HOLD, SCAN and DONE.
REQ-015 IDLE: o=0, o_valid=0, code_ready=en.
REQ-016 Transfer: code_valid && code_ready in IDLE or HOLD; on the next edge o=1<<code, idx=code, o_valid=1, state=HOLD (latency 1 cycle).
REQ-017 HOLD: o and idx hold the last accepted code; code_ready=en; each new transfer updates o one cycle later.
REQ-018 scan_start && en in IDLE or HOLD: enter SCAN next edge with idx=0, o=1, o_valid=1, dwell counter=0; code_ready=0 throughout SCAN.
REQ-019 Simultaneous scan_start and transfer: scan_start SHALL win and the code is not accepted.
REQ-020 SCAN: the counter increments each cycle; at DWELL-1 it clears and idx increments with o following; each idx SHALL be driven exactly DWELL cycles.
REQ-021 SCAN step at idx=2**N-1 with counter at DWELL-1: enter DONE; o=0, o_valid=0, scan_done=1 for exactly one cycle; idx SHALL NOT wrap to 0 while in SCAN.
REQ-022 DONE SHALL go to IDLE unconditionally on the next edge.
REQ-023 scan_start during SCAN SHALL be ignored.
REQ-024 en low in any state: next edge state=IDLE, o=0, o_valid=0, scan_done=0, counter=0; a sweep in progress SHALL be abandoned without a scan_done pulse.
REQ-025 o SHALL always be zero or exactly one-hot; o_valid=1 iff o is nonzero.

Reset
REQ-026 rst_n low at a rising edge SHALL set state=IDLE, o=0, o_valid=0, idx=0, scan_done=0 and counter=0; this takes priority over all inputs, including mid-sweep.
REQ-027 code_ready SHALL be 0 while rst_n is low and SHALL follow en from the first edge after rst_n is released.

Configuration
REQ-028 With macro ONEHOT_DECODER_SEQ_ACTIVE_LOW_EN defined, o SHALL be the bitwise inverse of the REQ-015..REQ-026 value (reset/idle all ones, selected bit 0); o_valid and all other ports are unchanged.
REQ-029 Without ONEHOT_DECODER_SEQ_ACTIVE_LOW_EN, o SHALL be active-high as specified above.

Verification (N=4, DWELL=4, macro undefined unless stated)
REQ-030 Reset, then en=1 and code=4'b0101 with code_valid for 1 cycle -> one cycle later o=16'h0020, idx=5 and o_valid=1; these SHALL hold while code_valid=0.
REQ-031 Back-to-back transfers of codes 0..15, one per cycle -> o sequence 16'h0001..16'h8000 with 1-cycle latency and no gaps.
REQ-032 Pulse scan_start -> idx 0..15, each held 4 cycles (64 cycles total), then o=0 with scan_done high exactly 1 cycle, then IDLE with code_ready=1.
REQ-033 en low at idx=7 mid-sweep -> o=0 next edge, no scan_done pulse; the same applies to rst_n low at idx=7, which also gives idx=0.
REQ-034 scan_start and code_valid (code=3) in the same cycle -> SCAN entered with o=16'h0001 and code 3 never appears.
REQ-035 Macro ONEHOT_DECODER_SEQ_ACTIVE_LOW_EN defined, code=2 accepted -> o=16'hFFFB; after reset o=16'hFFFF.

Source files
------------

// File: rtl/onehot_decoder_seq_if.sv
// onehot_decoder_seq_if -- bus between a code source and onehot_decoder_seq.
//   master: drives en, code, code_valid, scan_start; observes the decoder outputs.
//   slave : the decoder side (code_ready, o, o_valid, idx, scan_done are outputs).
// N must match the N of the decoder instance it is bound to.
interface onehot_decoder_seq_if #(
  parameter int N = 4
);
  logic            en;
  logic [N-1:0]    code;
  logic            code_valid;
  logic            code_ready;
  logic            scan_start;
  logic [2**N-1:0] o;
  logic            o_valid;
  logic [N-1:0]    idx;
  logic            scan_done;

  modport master (
    output en, code, code_valid, scan_start,
    input  code_ready, o, o_valid, idx, scan_done
  );

  modport slave (
    input  en, code, code_valid, scan_start,
    output code_ready, o, o_valid, idx, scan_done
  );
endinterface

// File: rtl/onehot_decoder_seq.sv
// onehot_decoder_seq -- registered binary-to-one-hot decoder with an automatic
// sweep mode.
//   clk   : single clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : onehot_decoder_seq_if.slave
//           en          global enable (low forces outputs to zero, state IDLE)
//           code/code_valid/code_ready  code transfer handshake
//           scan_start  request a sweep of all 2**N codes, each held DWELL cycles
//           o/o_valid/idx  registered one-hot output, valid flag, current code
//           scan_done   one-cycle pulse at sweep completion
// Optional macro ONEHOT_DECODER_SEQ_ACTIVE_LOW_EN: o is driven inverted
// (idle all ones, selected bit 0); every other output is unaffected.
module onehot_decoder_seq #(
  parameter int N     = 4,
  parameter int DWELL = 100
) (
  input logic               clk,
  input logic               rst_n,
  onehot_decoder_seq_if.slave bus
);
  localparam int          W        = 2**N;
  localparam logic [15:0] DW_LAST  = 16'(DWELL - 1);
  localparam logic [N-1:0] IDX_LAST = N'(W - 1);

  typedef enum logic [1:0] {IDLE, HOLD, SCAN, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   o_q, o_d;      // active-high one-hot, inverted at the port if configured
  logic           ov_q, ov_d;
  logic [N-1:0]   idx_q, idx_d;
  logic [15:0]    cnt_q, cnt_d;
  logic           done_q, done_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      o_q     <= '0;
      ov_q    <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      o_q     <= o_d;
      ov_q    <= ov_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    o_d     = o_q;
    ov_d    = ov_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (!bus.en) begin
      // Abandon whatever is in progress; idx is left as-is.
      state_d = IDLE;
      o_d     = '0;
      ov_d    = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE, HOLD: begin
          // scan_start outranks a simultaneous code transfer.
          if (bus.scan_start) begin
            state_d = SCAN;
            idx_d   = '0;
            o_d     = W'(1);
            ov_d    = 1'b1;
            cnt_d   = '0;
          end else if (bus.code_valid) begin
            state_d        = HOLD;
            idx_d          = bus.code;
            o_d            = '0;
            o_d[bus.code]  = 1'b1;
            ov_d           = 1'b1;
          end
        end
        SCAN: begin
          if (cnt_q == DW_LAST) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
              state_d = DONE;
              o_d     = '0;
              ov_d    = 1'b0;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
              o_d   = o_q << 1;
            end
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.code_ready = rst_n && bus.en && ((state_q == IDLE) || (state_q == HOLD));
  assign bus.o_valid    = ov_q;
  assign bus.idx        = idx_q;
  assign bus.scan_done  = done_q;
`ifdef ONEHOT_DECODER_SEQ_ACTIVE_LOW_EN
  assign bus.o = ~o_q;
`else
  assign bus.o = o_q;
`endif
endmodule
